// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Divide-by-zero quotient and the most negative signed value
  localparam logic [XLEN-1:0] QUOT_ONES = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final sign correction and result selection applied in the FIX state.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  op_e                  i_op,
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic                 i_neg_q,
  input  logic                 i_neg_r,
  output logic [WIDTH-1:0]     o_result_c
);

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  // Negate product / quotient / remainder as needed, then pick the half the op asks for
  always_comb begin
    w_prod     = i_neg_q ? -i_acc : i_acc;
    w_quo      = i_neg_q ? -i_acc[WIDTH-1:0] : i_acc[WIDTH-1:0];
    w_rem      = i_neg_r ? -i_acc[2*WIDTH-1:WIDTH] : i_acc[2*WIDTH-1:WIDTH];
    o_result_c = w_prod[WIDTH-1:0];
    case (i_op)
      OP_MUL:                        o_result_c = w_prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  o_result_c = w_prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               o_result_c = w_quo;
      default:                       o_result_c = w_rem;
    endcase
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle, stalls the
// front of the pipeline while an operation is in flight.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             R_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e             r_state;
  state_e             w_next;
  op_e                r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [CW-1:0]      r_cnt;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;

  op_e                w_op;
  logic               w_is_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_div_zero;
  logic               w_ovf;
  logic               w_accept;
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [2*WIDTH-1:0] w_div_step;
  logic [WIDTH-1:0]   w_fix_result;

  // Decode the incoming op: signedness, magnitudes and the CALC-skipping special cases
  always_comb begin
    w_op       = op_e'(op);
    w_is_div   = op[2];
    w_a_neg    = a[WIDTH-1] & ((w_op == OP_MULH) | (w_op == OP_MULHSU) |
                               (w_op == OP_DIV)  | (w_op == OP_REM));
    w_b_neg    = b[WIDTH-1] & ((w_op == OP_MULH) | (w_op == OP_DIV) | (w_op == OP_REM));
    w_a_mag    = w_a_neg ? -a : a;
    w_b_mag    = w_b_neg ? -b : b;
    w_div_zero = w_is_div & (b == '0);
    w_ovf      = ((w_op == OP_DIV) | (w_op == OP_REM)) &
                 (a == WIDTH'(INT_MIN)) & (b == WIDTH'(QUOT_ONES));
    w_accept   = (r_state == ST_IDLE) & start & ~flush;
  end

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
    w_mul_step = r_acc[0] ? {w_add, r_acc[WIDTH-1:1]}
                          : {1'b0, r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1:1]};
    w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_b});
    w_sub      = w_rem_sh[WIDTH-1:0] - r_b;
    w_div_step = w_ge ? {w_sub, r_acc[WIDTH-2:0], 1'b1}
                      : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
  end

  muldiv_sign_fix #(
    .WIDTH(WIDTH)
  ) u_sign_fix (
    .i_op       (r_op),
    .i_acc      (r_acc),
    .i_neg_q    (r_neg_q),
    .i_neg_r    (r_neg_r),
    .o_result_c (w_fix_result)
  );

  // State register
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; flush aborts from any state
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start) w_next = (w_div_zero | w_ovf) ? ST_FIX : ST_CALC;
        ST_CALC: if (r_cnt == '0) w_next = ST_FIX;
        ST_FIX:  w_next = ST_DONE;
        ST_DONE: w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Pipeline handshake outputs; stall is forced low while reset is asserted
  always_comb begin
    stall  = R_n & (w_accept | (r_state == ST_CALC) | (r_state == ST_FIX));
    busy   = (r_state != ST_IDLE);
    done   = r_done;
    result = r_result;
  end

  // Operand latch and iteration datapath; special cases preload the final quotient/remainder
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      r_op    <= OP_MUL;
      r_acc   <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_op  <= w_op;
      r_cnt <= CW'(WIDTH - 1);
      if (w_div_zero) begin
        r_acc   <= {a, WIDTH'(QUOT_ONES)};
        r_b     <= '0;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else if (w_ovf) begin
        r_acc   <= {{WIDTH{1'b0}}, WIDTH'(INT_MIN)};
        r_b     <= '0;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else if (w_is_div) begin
        r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
        r_b     <= w_b_mag;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end else begin
        r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
        r_b     <= w_a_mag;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= 1'b0;
      end
    end else if (r_state == ST_CALC) begin
      r_acc <= r_op[2] ? w_div_step : w_mul_step;
      if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
    end
  end

  // Capture the result and raise done on the FIX -> DONE transition
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= (w_next == ST_DONE);
      if (w_next == ST_DONE) r_result <= w_fix_result;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M cases, special cases,
// flush/reset aborts, back-to-back issue and a short random run.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        R_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] q_exp[$];

  ex_muldiv #(.WIDTH(32)) dut (
    .clk    (clk),
    .R_n    (R_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference model built on plain 64-bit and signed SV arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, sy, ux, uy, p;
    logic [31:0] r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    r  = '0;
    case (o)
      3'b000: begin p = ux * uy; r = p[31:0];  end
      3'b001: begin p = sx * sy; r = p[63:32]; end
      3'b010: begin p = sx * uy; r = p[63:32]; end
      3'b011: begin p = ux * uy; r = p[63:32]; end
      3'b100: if (y == 0) r = 32'hFFFF_FFFF;
              else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
              else r = 32'($signed(x) / $signed(y));
      3'b101: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b110: if (y == 0) r = x;
              else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
              else r = 32'($signed(x) % $signed(y));
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    flush = 1'b0;
    if (push) q_exp.push_back(ref_op(o, x, y));
  endtask

  // Called in cycle 0 (start just driven); returns at the done cycle or after the budget
  task automatic wait_done(input int budget, output int lat, output logic [31:0] res,
                           output int stall_low, output logic stall_done);
    bit got;
    got        = 1'b0;
    lat        = -1;
    res        = '0;
    stall_low  = 0;
    stall_done = 1'b1;
    #1;
    if (stall !== 1'b1) stall_low++;
    for (int k = 1; k <= budget && !got; k++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) begin
        got        = 1'b1;
        lat        = k;
        res        = result;
        stall_done = stall;
      end else if (stall !== 1'b1) begin
        stall_low++;
      end
    end
  endtask

  task automatic run_one(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic [31:0] res,
                         output int stall_low, output logic stall_done);
    @(negedge clk);
    drive(o, x, y, 1'b1);
    wait_done(60, lat, res, stall_low, stall_done);
    start = 1'b0;
  endtask

  function automatic logic [31:0] pop_exp();
    logic [31:0] e;
    e = 32'hDEAD_BEEF;
    if (q_exp.size() != 0) e = q_exp.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    R_n = 1'b0; start = 1'b1; flush = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0)    $display("FAIL reset_busy got %b want 0", busy);     else n_pass++;
    n_checks++; if (done !== 1'b0)    $display("FAIL reset_done got %b want 0", done);     else n_pass++;
    n_checks++; if (stall !== 1'b0)   $display("FAIL reset_stall got %b want 0", stall);   else n_pass++;
    n_checks++; if (result !== 32'd0) $display("FAIL reset_result got %h want 0", result); else n_pass++;
    start = 1'b0;
    @(negedge clk);
    R_n = 1'b1;
  endtask

  // Directed table: op, a, b, required result, required latency
  task automatic test_directed(input string name, input logic [2:0] ops[4], input logic [31:0] xs[4],
                               input logic [31:0] ys[4], input logic [31:0] want[4], input int want_lat);
    int lat, sl; logic [31:0] res, e; logic sd;
    for (int i = 0; i < 4; i++) begin
      run_one(ops[i], xs[i], ys[i], lat, res, sl, sd);
      e = pop_exp();
      n_checks++; if (lat !== want_lat) $display("FAIL %s_lat[%0d] got %0d want %0d", name, i, lat, want_lat); else n_pass++;
      n_checks++; if (res !== want[i])  $display("FAIL %s_res[%0d] got %h want %h", name, i, res, want[i]); else n_pass++;
      n_checks++; if (res !== e)        $display("FAIL %s_sb[%0d] got %h want %h", name, i, res, e); else n_pass++;
      n_checks++; if (sl !== 0)         $display("FAIL %s_stall_low[%0d] got %0d want 0", name, i, sl); else n_pass++;
      n_checks++; if (sd !== 1'b0)      $display("FAIL %s_stall_done[%0d] got %b want 0", name, i, sd); else n_pass++;
    end
  endtask

  task automatic test_mul();
    test_directed("mul",
      '{3'b000, 3'b001, 3'b011, 3'b010},
      '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2},
      '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF}, 34);
  endtask

  task automatic test_div();
    test_directed("div",
      '{3'b100, 3'b110, 3'b101, 3'b111},
      '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100},
      '{32'd2, 32'd2, 32'd7, 32'd7},
      '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2}, 34);
  endtask

  // Ends on REM 5/0 so the held result is a known non-zero value
  task automatic test_special();
    test_directed("special",
      '{3'b100, 3'b100, 3'b110, 3'b110},
      '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5},
      '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0},
      '{32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd5}, 2);
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    drive(3'b101, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0)  $display("FAIL flush_busy got %b want 0", busy);   else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL flush_stall got %b want 0", stall); else n_pass++;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0)       $display("FAIL flush_no_done got %0d pulses want 0", seen); else n_pass++;
    n_checks++; if (result !== 32'd5) $display("FAIL flush_result_held got %h want 5", result);   else n_pass++;
    // flush together with start in IDLE: not accepted
    @(negedge clk);
    drive(3'b100, 32'd9, 32'd3, 1'b0);
    flush = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL flush_start_stall got %b want 0", stall); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL flush_start_busy got %b want 0", busy); else n_pass++;
    flush = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(3'b101, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    #2;
    R_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0)    $display("FAIL rstmid_busy got %b want 0", busy);     else n_pass++;
    n_checks++; if (done !== 1'b0)    $display("FAIL rstmid_done got %b want 0", done);     else n_pass++;
    n_checks++; if (stall !== 1'b0)   $display("FAIL rstmid_stall got %b want 0", stall);   else n_pass++;
    n_checks++; if (result !== 32'd0) $display("FAIL rstmid_result got %h want 0", result); else n_pass++;
    start = 1'b0;
    @(negedge clk);
    R_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, sl1, sl2; logic [31:0] r1, r2, e1, e2; logic sd1, sd2;
    @(negedge clk);
    drive(3'b000, 32'd3, 32'd4, 1'b1);
    wait_done(60, lat1, r1, sl1, sd1);
    drive(3'b000, 32'd5, 32'd6, 1'b1);
    @(negedge clk);
    wait_done(60, lat2, r2, sl2, sd2);
    start = 1'b0;
    e1 = pop_exp();
    e2 = pop_exp();
    n_checks++; if (lat1 !== 34)            $display("FAIL b2b_done1_cycle got %0d want 34", lat1); else n_pass++;
    n_checks++; if (lat1 + 1 + lat2 !== 69) $display("FAIL b2b_done2_cycle got %0d want 69", lat1 + 1 + lat2); else n_pass++;
    n_checks++; if (r1 !== 32'd12)          $display("FAIL b2b_res1 got %h want 0000000c", r1); else n_pass++;
    n_checks++; if (r2 !== 32'd30)          $display("FAIL b2b_res2 got %h want 0000001e", r2); else n_pass++;
    n_checks++; if (r1 !== e1 || r2 !== e2) $display("FAIL b2b_sb got %h/%h want %h/%h", r1, r2, e1, e2); else n_pass++;
    n_checks++; if (sl1 + sl2 !== 0)        $display("FAIL b2b_stall_low got %0d want 0", sl1 + sl2); else n_pass++;
    n_checks++; if (sd1 !== 1'b0 || sd2 !== 1'b0) $display("FAIL b2b_stall_done got %b%b want 00", sd1, sd2); else n_pass++;
  endtask

  task automatic test_random();
    int lat, sl, want_lat; logic [31:0] res, e, x, y; logic [2:0] o; logic sd;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = (i == 2) ? 32'd0 : $urandom;
      if (i == 5) y = y >> $urandom_range(8, 30);
      want_lat = (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) ? 2 : 34;
      run_one(o, x, y, lat, res, sl, sd);
      e = pop_exp();
      n_checks++; if (res !== e)        $display("FAIL rand_res[%0d] op=%0d a=%h b=%h got %h want %h", i, o, x, y, res, e); else n_pass++;
      n_checks++; if (lat !== want_lat) $display("FAIL rand_lat[%0d] got %0d want %0d", i, lat, want_lat); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    n_checks++; if (q_exp.size() !== 0) $display("FAIL scoreboard_drain got %0d left want 0", q_exp.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
